wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 86 ++++++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter slice.
// A buffered entry is packed as {overflow, dst[4:0], result}.
package wb_arbiter_pkg;

  localparam int DEF_REG_SIZE = 32;
  localparam int WB_ENTRY_W   = DEF_REG_SIZE + 5 + 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MUL,
    SEL_BUF,
    SEL_BYP
  } sel_e;

  // r0 results are architecturally dead unless they raise an exception.
  function automatic logic is_r0_drop(input logic [4:0] dst, input logic ovf);
    return (dst == 5'd0) && !ovf;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for ALU results that lost arbitration to M5, plus a
// forwarding CAM that returns the youngest matching buffered value.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int REG_SIZE = DEF_REG_SIZE,
  parameter int DEPTH    = 4,
  localparam int ENTRY_W = REG_SIZE + 6,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_entry,
  output logic               full,
  output logic               empty,
  input  logic [4:0]         fwd_reg,
  output logic               fwd_hit,
  output logic [REG_SIZE-1:0] fwd_data
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [AW:0]        count;
  logic               push_ok;
  logic               pop_ok;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign head_entry = mem[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push_ok) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop_ok) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload needs no reset: the valid bits gate every read of it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= push_entry;
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [AW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (valid[idx] && (fwd_reg != 5'd0) &&
          (mem[idx][REG_SIZE+4:REG_SIZE] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[idx][REG_SIZE-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: M5 always wins, colliding ALU results queue in
// wb_fifo, and exec1 is stalled while that queue is full.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int REG_SIZE = DEF_REG_SIZE,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [4:0]          alu_dst,
  input  logic [REG_SIZE-1:0] alu_result,
  input  logic                alu_overflow,
  output logic                alu_stall,
  input  logic                mul_valid,
  input  logic [4:0]          mul_dst,
  input  logic [REG_SIZE-1:0] mul_result,
  input  logic                mul_overflow,
  input  logic [4:0]          fwd_reg,
  output logic                fwd_hit,
  output logic [REG_SIZE-1:0] fwd_data,
  output logic                wb_en,
  output logic [4:0]          wb_dst,
  output logic [REG_SIZE-1:0] wb_data,
  output logic                exc_overflow,
  output logic [4:0]          exc_dst
);

  localparam int ENTRY_W = REG_SIZE + 6;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] alu_entry;
  logic [ENTRY_W-1:0] mul_entry;
  logic [ENTRY_W-1:0] sel_entry;
  logic               alu_keep;
  sel_e               sel;
  logic               sel_ovf;
  logic [4:0]         sel_dst;
  logic [REG_SIZE-1:0] sel_data;
  logic               do_write;
  logic               do_exc;

  wb_fifo #(
    .REG_SIZE(REG_SIZE),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_entry(alu_entry),
    .pop       (fifo_pop),
    .head_entry(head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fwd_reg   (fwd_reg),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  assign alu_stall = fifo_full;
  assign alu_entry = {alu_overflow, alu_dst, alu_result};
  assign mul_entry = {mul_overflow, mul_dst, mul_result};

  // Dead r0 ALU results are consumed here and never occupy a slot.
  assign alu_keep = alu_valid && !alu_stall && !is_r0_drop(alu_dst, alu_overflow);

  always_comb begin
    sel       = SEL_NONE;
    sel_entry = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (mul_valid) begin
      sel       = SEL_MUL;
      sel_entry = mul_entry;
      fifo_push = alu_keep;
    end else if (!fifo_empty) begin
      sel       = SEL_BUF;
      sel_entry = head_entry;
      fifo_pop  = 1'b1;
      fifo_push = alu_keep;
    end else if (alu_keep) begin
      sel       = SEL_BYP;
      sel_entry = alu_entry;
    end
  end

  assign sel_ovf  = sel_entry[ENTRY_W-1];
  assign sel_dst  = sel_entry[REG_SIZE+4:REG_SIZE];
  assign sel_data = sel_entry[REG_SIZE-1:0];
  assign do_exc   = (sel != SEL_NONE) && sel_ovf;
  assign do_write = (sel != SEL_NONE) && !is_r0_drop(sel_dst, sel_ovf) && !sel_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en        <= 1'b0;
      wb_dst       <= '0;
      wb_data      <= '0;
      exc_overflow <= 1'b0;
      exc_dst      <= '0;
    end else begin
      wb_en        <= do_write;
      wb_dst       <= do_write ? sel_dst : 5'd0;
      wb_data      <= do_write ? sel_data : '0;
      exc_overflow <= do_exc;
      exc_dst      <= do_exc ? sel_dst : 5'd0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed cycle table, reset-in-flight sequence and
// a randomized run checked against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH_TB = 4;
  localparam int OUT_W    = 1 + 5 + 32 + 1 + 5;

  typedef struct {
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mr;
    logic        mo;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] ar;
    logic        ao;
    logic [4:0]  fr;
    logic        s_stall;
    logic        s_hit;
    logic [31:0] s_fwd;
    logic        e_wen;
    logic [4:0]  e_dst;
    logic [31:0] e_data;
    logic        e_exc;
    logic [4:0]  e_edst;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_dst = '0;
  logic [31:0] alu_result = '0;
  logic        alu_overflow = 1'b0;
  logic        alu_stall;
  logic        mul_valid = 1'b0;
  logic [4:0]  mul_dst = '0;
  logic [31:0] mul_result = '0;
  logic        mul_overflow = 1'b0;
  logic [4:0]  fwd_reg = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        wb_en;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        exc_overflow;
  logic [4:0]  exc_dst;

  logic [OUT_W-1:0]      exp_q[$];
  logic [WB_ENTRY_W-1:0] mq[$];
  vec_t                  tbl[$];
  int n_checks = 0;
  int n_pass   = 0;

  wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_dst     (alu_dst),
    .alu_result  (alu_result),
    .alu_overflow(alu_overflow),
    .alu_stall   (alu_stall),
    .mul_valid   (mul_valid),
    .mul_dst     (mul_dst),
    .mul_result  (mul_result),
    .mul_overflow(mul_overflow),
    .fwd_reg     (fwd_reg),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .wb_en       (wb_en),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .exc_overflow(exc_overflow),
    .exc_dst     (exc_dst)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t v(
    input logic mv, input logic [4:0] md, input logic [31:0] mr, input logic mo,
    input logic av, input logic [4:0] ad, input logic [31:0] ar, input logic ao,
    input logic [4:0] fr, input logic ss, input logic sh, input logic [31:0] sf,
    input logic ew, input logic [4:0] ed, input logic [31:0] edata,
    input logic ee, input logic [4:0] eed);
    vec_t r;
    r.mv = mv; r.md = md; r.mr = mr; r.mo = mo;
    r.av = av; r.ad = ad; r.ar = ar; r.ao = ao;
    r.fr = fr; r.s_stall = ss; r.s_hit = sh; r.s_fwd = sf;
    r.e_wen = ew; r.e_dst = ed; r.e_data = edata; r.e_exc = ee; r.e_edst = eed;
    return r;
  endfunction

  function automatic vec_t idle(input logic [4:0] fr, input logic sh, input logic [31:0] sf,
                                input logic ew, input logic [4:0] ed, input logic [31:0] edata);
    return v(0, 0, 0, 0, 0, 0, 0, 0, fr, 0, sh, sf, ew, ed, edata, 0, 0);
  endfunction

  // Driver: entered just after a rising edge; checks combinational outputs,
  // queues the expected registered result and compares it after the edge.
  task automatic apply(input vec_t r);
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] want;
    mul_valid = r.mv; mul_dst = r.md; mul_result = r.mr; mul_overflow = r.mo;
    alu_valid = r.av; alu_dst = r.ad; alu_result = r.ar; alu_overflow = r.ao;
    fwd_reg = r.fr;
    #1;
    chk("alu_stall", 64'(alu_stall), 64'(r.s_stall));
    chk("fwd_hit", 64'(fwd_hit), 64'(r.s_hit));
    chk("fwd_data", 64'(fwd_data), 64'(r.s_fwd));
    exp_q.push_back({r.e_wen, r.e_dst, r.e_data, r.e_exc, r.e_edst});
    @(posedge clk);
    #1;
    got  = {wb_en, wb_dst, wb_data, exc_overflow, exc_dst};
    want = exp_q.pop_front();
    chk("wb_outputs", 64'(got), 64'(want));
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_exc", 64'(exc_overflow), 64'd0);
    chk("rst_stall", 64'(alu_stall), 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Bypass, collision, full buffer with stall, overflow/r0, forwarding
    tbl.push_back(v(0, 0, 0, 0, 1, 3, 'h12, 0, 0, 0, 0, 0, 1, 3, 'h12, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 5, 'hAA, 0, 1, 6, 'hBB, 0, 0, 0, 0, 0, 1, 5, 'hAA, 0, 0));
    tbl.push_back(idle(0, 0, 0, 1, 6, 'hBB));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 10, 'h100, 0, 1, 11, 'h200, 0, 0, 0, 0, 0, 1, 10, 'h100, 0, 0));
    tbl.push_back(v(1, 12, 'h101, 0, 1, 13, 'h201, 0, 0, 0, 0, 0, 1, 12, 'h101, 0, 0));
    tbl.push_back(v(1, 14, 'h102, 0, 1, 15, 'h202, 0, 0, 0, 0, 0, 1, 14, 'h102, 0, 0));
    tbl.push_back(v(1, 16, 'h103, 0, 1, 17, 'h203, 0, 0, 0, 0, 0, 1, 16, 'h103, 0, 0));
    tbl.push_back(v(1, 18, 'h104, 0, 1, 19, 'h204, 0, 13, 1, 1, 'h201, 1, 18, 'h104, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 19, 'h204, 0, 0, 1, 0, 0, 1, 11, 'h200, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 19, 'h204, 0, 0, 0, 0, 0, 1, 13, 'h201, 0, 0));
    tbl.push_back(idle(0, 0, 0, 1, 15, 'h202));
    tbl.push_back(idle(0, 0, 0, 1, 17, 'h203));
    tbl.push_back(idle(19, 1, 'h204, 1, 19, 'h204));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 9, 'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 4, 'h9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4));
    tbl.push_back(v(1, 0, 'h33, 0, 1, 8, 'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(8, 1, 'h44, 1, 8, 'h44));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 20, 'h1, 0, 1, 7, 'h1, 0, 7, 0, 0, 0, 1, 20, 'h1, 0, 0));
    tbl.push_back(v(1, 21, 'h2, 0, 1, 7, 'h2, 0, 7, 0, 1, 'h1, 1, 21, 'h2, 0, 0));
    tbl.push_back(v(1, 22, 'h3, 0, 0, 0, 0, 0, 7, 0, 1, 'h2, 1, 22, 'h3, 0, 0));
    tbl.push_back(v(1, 23, 'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 23, 'h4, 0, 0));
    tbl.push_back(v(1, 24, 'h5, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1, 24, 'h5, 0, 0));
    tbl.push_back(idle(7, 1, 'h2, 1, 7, 'h1));
    tbl.push_back(idle(7, 1, 'h2, 1, 7, 'h2));
    tbl.push_back(idle(7, 0, 0, 0, 0, 0));
    // Three entries buffered ahead of the mid-operation reset
    tbl.push_back(v(1, 28, 'h28, 0, 1, 25, 'h25, 0, 0, 0, 0, 0, 1, 28, 'h28, 0, 0));
    tbl.push_back(v(1, 29, 'h29, 0, 1, 26, 'h26, 0, 0, 0, 0, 0, 1, 29, 'h29, 0, 0));
    tbl.push_back(v(1, 30, 'h30, 0, 1, 27, 'h27, 0, 0, 0, 0, 0, 1, 30, 'h30, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-operation
    mul_valid = 1'b0; alu_valid = 1'b0; fwd_reg = 5'd25;
    #1;
    chk("pre_rst_count", 64'(dut.u_fifo.count), 64'd3);
    chk("pre_rst_fwd", 64'(fwd_hit), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_wb_en", 64'(wb_en), 64'd0);
    chk("midrst_wb_dst", 64'(wb_dst), 64'd0);
    chk("midrst_wb_data", 64'(wb_data), 64'd0);
    chk("midrst_count", 64'(dut.u_fifo.count), 64'd0);
    chk("midrst_fwd_hit", 64'(fwd_hit), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) apply(idle(25, 0, 0, 0, 0, 0));

    // Randomized traffic against the reference queue model
    for (int n = 0; n < 400; n++) begin
      vec_t r;
      logic [WB_ENTRY_W-1:0] sel;
      logic selv;
      logic keep;
      r.mv = ($urandom_range(0, 9) < 5);
      r.md = 5'($urandom_range(0, 7));
      r.mr = $urandom;
      r.mo = ($urandom_range(0, 15) == 0);
      r.av = ($urandom_range(0, 9) < 7);
      r.ad = 5'($urandom_range(0, 7));
      r.ar = $urandom;
      r.ao = ($urandom_range(0, 15) == 0);
      r.fr = 5'($urandom_range(0, 7));
      r.s_stall = (mq.size() == DEPTH_TB);
      r.s_hit = 1'b0;
      r.s_fwd = '0;
      foreach (mq[k]) begin
        if (r.fr != 5'd0 && mq[k][36:32] == r.fr) begin
          r.s_hit = 1'b1;
          r.s_fwd = mq[k][31:0];
        end
      end
      keep = r.av && !r.s_stall && !(r.ad == 5'd0 && !r.ao);
      selv = 1'b1;
      sel  = '0;
      if (r.mv) begin
        sel = {r.mo, r.md, r.mr};
        if (keep) mq.push_back({r.ao, r.ad, r.ar});
      end else if (mq.size() > 0) begin
        sel = mq.pop_front();
        if (keep) mq.push_back({r.ao, r.ad, r.ar});
      end else if (keep) begin
        sel = {r.ao, r.ad, r.ar};
      end else begin
        selv = 1'b0;
      end
      r.e_exc  = selv && sel[37];
      r.e_edst = r.e_exc ? sel[36:32] : 5'd0;
      r.e_wen  = selv && !sel[37] && (sel[36:32] != 5'd0);
      r.e_dst  = r.e_wen ? sel[36:32] : 5'd0;
      r.e_data = r.e_wen ? sel[31:0] : 32'd0;
      apply(r);
    end

    // Report
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
